// File: rtl/user_bram_pkg.sv
// Shared types and constants for the user-project BRAM arbiter.
// Both the top and the round-robin sub-module import this package.
package user_bram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  typedef enum logic {
    OWN_WB  = 1'b0,
    OWN_ACC = 1'b1
  } owner_e;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h3800_0000;

  // Byte write enables presented to the BRAM: reads must never write.
  function automatic logic [3:0] bram_byte_we(input logic we, input logic [3:0] strb);
    return we ? strb : 4'h0;
  endfunction

endpackage

// File: rtl/user_bram_arbiter_rr_arb2.sv
// Two-way round-robin arbiter between the Wishbone and accelerator requesters.
// The pointer remembers the last owner and only moves on the update strobe.
module rr_arb2
  import user_bram_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_wb,
  input  logic req_acc,
  input  logic update,
  input  logic upd_acc,
  output logic gnt_valid,
  output logic gnt_acc
);

  owner_e last_q, last_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    last_d = last_q;
    if (update) begin
      last_d = upd_acc ? OWN_ACC : OWN_WB;
    end
  end

  // Reset to "last = ACC" so the Wishbone side wins the first tie.
  // NOTE: sequential state uses non-blocking assignments only; blocking here would race other flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= OWN_ACC;
    end else begin
      last_q <= last_d;
    end
  end

  assign gnt_valid = req_wb | req_acc;
  assign gnt_acc   = req_acc & (~req_wb | (last_q == OWN_WB));

endmodule

// File: rtl/user_bram_arbiter.sv
// Shares the single-port user BRAM between Wishbone and an accelerator port with
// round-robin arbitration and a fixed IDLE->ACCESS->WAIT->RESP response latency.
module user_bram_arbiter
  import user_bram_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BRAM_LAT  = 1,
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic              acc_req,
  input  logic              acc_we,
  input  logic [3:0]        acc_wstrb,
  input  logic [ADDR_W-1:0] acc_addr,
  input  logic [31:0]       acc_wdata,
  output logic              acc_gnt,
  output logic              acc_ack,
  output logic [31:0]       acc_rdata,
  output logic              bram_en,
  output logic [3:0]        bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [31:0]       bram_wdata,
  input  logic [31:0]       bram_rdata
);

  // BRAM_LAT must be at least 1; the WAIT counter counts down from BRAM_LAT-1.
  localparam int unsigned     CNT_W    = (BRAM_LAT > 1) ? $clog2(BRAM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BRAM_LAT - 1);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              we_q, we_d;
  logic [3:0]        strb_q, strb_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       wb_rdata_q, wb_rdata_d;
  logic [31:0]       acc_rdata_q, acc_rdata_d;

  logic wb_hit;
  logic arb_valid;
  logic arb_acc;
  logic arb_update;

  assign wb_hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24] == BASE_ADDR[31:24]);

  rr_arb2 u_rr_arb2 (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .req_wb    (wb_hit),
    .req_acc   (acc_req),
    .update    (arb_update),
    .upd_acc   (owner_q == OWN_ACC),
    .gnt_valid (arb_valid),
    .gnt_acc   (arb_acc)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    strb_d      = strb_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    wb_rdata_d  = wb_rdata_q;
    acc_rdata_d = acc_rdata_q;
    arb_update  = 1'b0;
    bram_en     = 1'b0;
    bram_we     = 4'h0;
    bram_addr   = '0;
    bram_wdata  = 32'h0;
    acc_gnt     = 1'b0;
    acc_ack     = 1'b0;
    wbs_ack_o   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Arbitration happens only here; the winner's request is frozen for the access.
        if (arb_valid) begin
          if (arb_acc) begin
            owner_d = OWN_ACC;
            we_d    = acc_we;
            strb_d  = acc_wstrb;
            addr_d  = acc_addr;
            wdata_d = acc_wdata;
          end else begin
            owner_d = OWN_WB;
            we_d    = wbs_we_i;
            strb_d  = wbs_sel_i;
            addr_d  = wbs_adr_i[ADDR_W+1:2];
            wdata_d = wbs_dat_i;
          end
          state_d = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        bram_en    = 1'b1;
        bram_we    = bram_byte_we(we_q, strb_q);
        bram_addr  = addr_q;
        bram_wdata = wdata_q;
        acc_gnt    = (owner_q == OWN_ACC);
        arb_update = 1'b1;
        cnt_d      = CNT_LOAD;
        state_d    = ST_WAIT;
      end

      ST_WAIT: begin
        if (cnt_q == '0) begin
          if (!we_q) begin
            if (owner_q == OWN_WB) begin
              wb_rdata_d = bram_rdata;
            end else begin
              acc_rdata_d = bram_rdata;
            end
          end
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_RESP: begin
        wbs_ack_o = (owner_q == OWN_WB);
        acc_ack   = (owner_q == OWN_ACC);
        state_d   = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: the captured request and read-data registers are reset along with the
  // state, so every output reads 0 after reset and an abandoned access leaves no trace.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_WB;
      we_q        <= 1'b0;
      strb_q      <= 4'h0;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      cnt_q       <= '0;
      wb_rdata_q  <= 32'h0;
      acc_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      strb_q      <= strb_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      wb_rdata_q  <= wb_rdata_d;
      acc_rdata_q <= acc_rdata_d;
    end
  end

  assign wbs_dat_o = wb_rdata_q;
  assign acc_rdata = acc_rdata_q;

endmodule
